relu_maxpool: RTL and testbench

//  Downstream stage of the 3x3x3 convolution layer. Consumes its 16-bit per-pixel

---
 rtl/relu_maxpool_pkg.sv | 35 +++
 rtl/relu_maxpool_if.sv | 29 ++
 rtl/relu_maxpool_line_buf.sv | 28 ++
 rtl/relu_maxpool.sv | 160 ++++++++++++++++
 tb/tb_relu_maxpool.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/relu_maxpool_pkg.sv
// Shared types and arithmetic helpers for the bias/ReLU/max-pool stage.
// Latency: n/a (package, combinational helpers only).
// Backpressure: n/a.
package relu_maxpool_pkg;

    // Sample width the helper functions are built for; the stage must use the same width.
    localparam int DATA_W_DFLT = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Clamp a (DATA_W+1)-bit signed sum into 0 .. 2^(DATA_W-1)-1.
    // The sum is known non-negative when its top bit is clear, so it exceeds
    // the positive limit exactly when bit DATA_W-1 is set.
    function automatic logic [DATA_W_DFLT-1:0] relu_sat(input logic signed [DATA_W_DFLT:0] s);
        logic [DATA_W_DFLT-1:0] res;
        if (s[DATA_W_DFLT]) begin
            res = '0;
        end else if (s[DATA_W_DFLT-1]) begin
            res = {1'b0, {(DATA_W_DFLT-1){1'b1}}};
        end else begin
            res = s[DATA_W_DFLT-1:0];
        end
        return res;
    endfunction

    // Unsigned maximum of two samples.
    function automatic logic [DATA_W_DFLT-1:0] umax(input logic [DATA_W_DFLT-1:0] a,
                                                    input logic [DATA_W_DFLT-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_maxpool_if.sv
// Stream bundle between the conv layer, the pooling stage and the BRAM writer.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take every out_valid strobe.
interface relu_maxpool_if
    import relu_maxpool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = 5
);
    logic signed [DATA_W-1:0]  bias;
    logic                      in_valid;
    logic                      in_sof;
    logic signed [DATA_W-1:0]  in_data;
    logic                      out_valid;
    logic        [DATA_W-1:0]  out_data;
    logic        [2*CNT_W-1:0] out_addr;
    logic                      frame_done;
    logic                      err_sof;

    modport master (
        output bias, in_valid, in_sof, in_data,
        input  out_valid, out_data, out_addr, frame_done, err_sof
    );

    modport slave (
        input  bias, in_valid, in_sof, in_data,
        output out_valid, out_data, out_addr, frame_done, err_sof
    );
endinterface

// File: rtl/relu_maxpool_line_buf.sv
// One row of horizontal pair maxima, written on even rows and read on odd rows.
// Latency: write visible the cycle after the write edge; read is combinational.
// Backpressure: none.
module pool_line_buf #(
    parameter int DEPTH  = 13,
    parameter int DATA_W = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_dat
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents need no reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/relu_maxpool.sv
// Per-channel bias add, saturating ReLU and 2x2/stride-2 max-pool over a raster stream.
// Latency: pooled strobe 2 cycles after the input beat of the odd-row/odd-col pixel.
// Backpressure: none; input gaps allowed, every output strobe must be accepted.
module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int IMG_W  = 26,
    parameter int IMG_H  = 26,
    parameter int CNT_W  = 5
) (
    input  logic         clk,
    input  logic         RESET_n,
    relu_maxpool_if.slave bus
);

    localparam int POOL_W = IMG_W / 2;
    localparam int POOL_H = IMG_H / 2;
    localparam int LB_AW  = (POOL_W > 1) ? $clog2(POOL_W) : 1;

    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] PCOL_LAST = CNT_W'(POOL_W - 1);
    localparam logic [CNT_W-1:0] PROW_LAST = CNT_W'(POOL_H - 1);

    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_row, r_col, w_row_nxt, w_col_nxt;
    logic [CNT_W-1:0]         w_row, w_col;
    logic                     w_start, w_acc, w_err;
    logic signed [DATA_W-1:0] r_bias, w_bias;
    logic signed [DATA_W:0]   w_sum;
    logic [DATA_W-1:0]        w_relu;

    logic                     r_s1_vld;
    logic [DATA_W-1:0]        r_s1_dat;
    logic [CNT_W-1:0]         r_s1_row, r_s1_col;

    logic                     w_s2_go, w_emit, w_lb_wr;
    logic [DATA_W-1:0]        r_hold, w_hmax, w_lb_rd;
    logic [LB_AW-1:0]         w_lb_addr;
    logic [CNT_W-1:0]         w_prow, w_pcol;

    logic                     r_out_vld, r_frame_done, r_err;
    logic [DATA_W-1:0]        r_out_dat;
    logic [2*CNT_W-1:0]       r_out_addr;

    // A start-of-frame beat always restarts the frame at pixel (0,0), even mid-frame.
    assign w_start = bus.in_valid & bus.in_sof;
    assign w_acc   = w_start | (bus.in_valid & (r_state == ST_RUN));
    assign w_err   = w_start & (r_state == ST_RUN) & ((r_row != '0) | (r_col != '0));
    assign w_row   = w_start ? '0 : r_row;
    assign w_col   = w_start ? '0 : r_col;
    // The start pixel itself already uses the freshly sampled bias.
    assign w_bias  = w_start ? bus.bias : r_bias;

    assign w_sum   = {bus.in_data[DATA_W-1], bus.in_data} + {w_bias[DATA_W-1], w_bias};
    assign w_relu  = relu_sat(w_sum);

    // Next state and raster position for the accepted beat.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        if (w_acc) begin
            if (w_col == COL_LAST) begin
                w_col_nxt = '0;
                if (w_row == ROW_LAST) begin
                    w_row_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_row_nxt   = w_row + CNT_W'(1);
                    w_state_nxt = ST_RUN;
                end
            end else begin
                w_col_nxt   = w_col + CNT_W'(1);
                w_row_nxt   = w_row;
                w_state_nxt = ST_RUN;
            end
        end
    end

    // State register, counters, held bias and the stage-1 ReLU register.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state  <= ST_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_bias   <= '0;
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
            r_s1_row <= '0;
            r_s1_col <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            if (w_start) begin
                r_bias <= bus.bias;
            end
            r_s1_vld <= w_acc;
            if (w_acc) begin
                r_s1_dat <= w_relu;
                r_s1_row <= w_row;
                r_s1_col <= w_col;
            end
        end
    end

    // A restart on this edge kills whatever old-frame pixel sits in stage 1.
    assign w_s2_go   = r_s1_vld & ~w_err;
    assign w_hmax    = r_s1_col[0] ? umax(r_hold, r_s1_dat) : r_s1_dat;
    assign w_lb_wr   = w_s2_go & ~r_s1_row[0] & r_s1_col[0];
    assign w_emit    = w_s2_go &  r_s1_row[0] & r_s1_col[0];
    assign w_prow    = r_s1_row >> 1;
    assign w_pcol    = r_s1_col >> 1;
    assign w_lb_addr = LB_AW'(w_pcol);

    pool_line_buf #(
        .DEPTH  (POOL_W),
        .DATA_W (DATA_W),
        .AW     (LB_AW)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_lb_wr),
        .i_wr_addr (w_lb_addr),
        .i_wr_dat  (w_hmax),
        .i_rd_addr (w_lb_addr),
        .o_rd_dat  (w_lb_rd)
    );

    // Stage 2: horizontal pair hold and the registered pooled output strobe.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_hold       <= '0;
            r_out_vld    <= 1'b0;
            r_out_dat    <= '0;
            r_out_addr   <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_s2_go & ~r_s1_col[0]) begin
                r_hold <= r_s1_dat;
            end
            r_out_vld <= w_emit;
            if (w_emit) begin
                r_out_dat  <= umax(w_lb_rd, w_hmax);
                r_out_addr <= {w_prow, w_pcol};
            end
            r_frame_done <= w_emit & (w_prow == PROW_LAST) & (w_pcol == PCOL_LAST);
            r_err        <= w_err;
        end
    end

    assign bus.out_valid  = r_out_vld;
    assign bus.out_data   = r_out_dat;
    assign bus.out_addr   = r_out_addr;
    assign bus.frame_done = r_frame_done;
    assign bus.err_sof    = r_err;

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench: 4x4 and 5x5 instances, expected pooled pixels queued at drive time.
// Latency: expected strobe cycle is the drive cycle of the odd/odd pixel plus 2.
// Backpressure: none; every strobe is popped and compared.
module tb_relu_maxpool;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;

    typedef struct {
        int dat;
        int addr;
        int fd;
        int cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q5[$];
    int   eq4[$];
    int   eq5[$];

    relu_maxpool_if #(.DATA_W(16), .CNT_W(5)) bus4 ();
    relu_maxpool_if #(.DATA_W(16), .CNT_W(5)) bus5 ();

    relu_maxpool #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .CNT_W(5)) u_dut4 (
        .clk     (clk),
        .RESET_n (rst_n),
        .bus     (bus4)
    );

    relu_maxpool #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .CNT_W(5)) u_dut5 (
        .clk     (clk),
        .RESET_n (rst_n),
        .bus     (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int relu_ref(input int s);
        if (s < 0) return 0;
        if (s > 32767) return 32767;
        return s;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Compare one DUT's outputs against its queues at this sampling point.
    task automatic monitor(input bit sel, input logic ov, input int od, input int oa,
                           input logic fd, input logic er);
        exp_t e;
        int   ec;
        if (sel ? (q5.size() > 0 && q5[0].cyc < cyc) : (q4.size() > 0 && q4[0].cyc < cyc)) begin
            e = sel ? q5.pop_front() : q4.pop_front();
            check(sel ? "missing_out5" : "missing_out4", cyc, e.cyc);
        end
        if (ov) begin
            if (sel ? (q5.size() == 0) : (q4.size() == 0)) begin
                check(sel ? "unexpected_out5" : "unexpected_out4", 1, 0);
            end else begin
                e = sel ? q5.pop_front() : q4.pop_front();
                check(sel ? "data5" : "data4", od, e.dat);
                check(sel ? "addr5" : "addr4", oa, e.addr);
                check(sel ? "frame_done5" : "frame_done4", int'(fd), e.fd);
                check(sel ? "latency5" : "latency4", cyc, e.cyc);
            end
        end else if (fd) begin
            check(sel ? "stray_frame_done5" : "stray_frame_done4", 1, 0);
        end
        if (sel ? (eq5.size() > 0 && eq5[0] < cyc) : (eq4.size() > 0 && eq4[0] < cyc)) begin
            ec = sel ? eq5.pop_front() : eq4.pop_front();
            check(sel ? "missing_err5" : "missing_err4", cyc, ec);
        end
        if (er) begin
            if (sel ? (eq5.size() == 0) : (eq4.size() == 0)) begin
                check(sel ? "unexpected_err5" : "unexpected_err4", 1, 0);
            end else begin
                ec = sel ? eq5.pop_front() : eq4.pop_front();
                check(sel ? "err_cycle5" : "err_cycle4", cyc, ec);
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(1'b0, bus4.out_valid, int'(bus4.out_data), int'(bus4.out_addr),
                bus4.frame_done, bus4.err_sof);
        monitor(1'b1, bus5.out_valid, int'(bus5.out_data), int'(bus5.out_addr),
                bus5.frame_done, bus5.err_sof);
    end

    task automatic set_in(input bit sel, input bit v, input bit sof, input int d, input int b);
        if (sel) begin
            bus5.in_valid = v;
            bus5.in_sof   = sof;
            bus5.in_data  = 16'(d);
            bus5.bias     = 16'(b);
        end else begin
            bus4.in_valid = v;
            bus4.in_sof   = sof;
            bus4.in_data  = 16'(d);
            bus4.bias     = 16'(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b0, 0, 0);
            set_in(1'b1, 1'b0, 1'b0, 0, 0);
        end
    endtask

    // Drive up to npix raster beats (mode 0: value = pixel index, else constant val).
    task automatic run_frame(input bit sel, input int w, input int h, input int b,
                             input int mode, input int val, input int gap_pct,
                             input int npix, input bit exp_err);
        int   rv [8][8];
        int   n;
        int   d;
        int   g;
        exp_t e;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n >= npix) return;
                d = (mode == 0) ? (r * w + c) : val;
                if (n > 0) begin
                    g = 0;
                    while (g < 3 && $urandom_range(0, 99) < gap_pct) begin
                        @(negedge clk);
                        set_in(sel, 1'b0, 1'b0, 0, b);
                        g++;
                    end
                end
                @(negedge clk);
                set_in(sel, 1'b1, (n == 0), d, b);
                if (n == 0 && exp_err) begin
                    if (sel) eq5.push_back(cyc + 1);
                    else     eq4.push_back(cyc + 1);
                end
                rv[r][c] = relu_ref(d + b);
                if ((r % 2) == 1 && (c % 2) == 1 && r < 2 * (h / 2) && c < 2 * (w / 2)) begin
                    e.dat  = max2(max2(rv[r-1][c-1], rv[r-1][c]), max2(rv[r][c-1], rv[r][c]));
                    e.addr = (r / 2) * 32 + (c / 2);
                    e.fd   = ((r / 2) == (h / 2 - 1) && (c / 2) == (w / 2 - 1)) ? 1 : 0;
                    e.cyc  = cyc + 2;
                    if (sel) q5.push_back(e);
                    else     q4.push_back(e);
                end
                n++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 0, 0);
        set_in(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_out_valid",  int'(bus4.out_valid),  0);
        check("rst_out_data",   int'(bus4.out_data),   0);
        check("rst_out_addr",   int'(bus4.out_addr),   0);
        check("rst_frame_done", int'(bus4.frame_done), 0);
        check("rst_err_sof",    int'(bus4.err_sof),    0);
        rst_n = 1'b1;
        idle(2);

        // Plain raster 0..15, zero bias.
        run_frame(1'b0, 4, 4, 0, 0, 0, 0, 99, 1'b0);
        idle(4);

        // Clamp to zero, positive saturation, negative input, frames back to back.
        run_frame(1'b0, 4, 4, -10, 1, 3, 0, 99, 1'b0);
        run_frame(1'b0, 4, 4, 1, 1, 32767, 0, 99, 1'b0);
        run_frame(1'b0, 4, 4, 5, 1, -20, 0, 99, 1'b0);
        idle(4);

        // Random input gaps must not change values, addresses or strobe latency.
        run_frame(1'b0, 4, 4, 0, 0, 0, 40, 99, 1'b0);
        idle(4);
        run_frame(1'b0, 4, 4, 100, 0, 0, 60, 99, 1'b0);
        idle(4);

        // Restart on beat 6: aborted frame yields nothing, new frame with new bias is correct.
        run_frame(1'b0, 4, 4, 0, 0, 0, 0, 5, 1'b0);
        run_frame(1'b0, 4, 4, 3, 0, 0, 0, 99, 1'b1);
        idle(4);

        // Reset mid-frame after beat 9, then beats without start are dropped.
        run_frame(1'b0, 4, 4, 0, 0, 0, 0, 9, 1'b0);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus4.out_valid), 0);
        check("midrst_out_data",  int'(bus4.out_data),  0);
        check("midrst_out_addr",  int'(bus4.out_addr),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            set_in(1'b0, 1'b1, 1'b0, 9, 0);
        end
        idle(4);
        run_frame(1'b0, 4, 4, 2, 0, 0, 0, 99, 1'b0);
        idle(4);

        // Odd frame size: last row and column are never pooled.
        run_frame(1'b1, 5, 5, 0, 0, 0, 0, 99, 1'b0);
        idle(6);

        check("queue4_drained",     q4.size(),  0);
        check("queue5_drained",     q5.size(),  0);
        check("err_queue4_drained", eq4.size(), 0);
        check("err_queue5_drained", eq5.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
